// File: rtl/image_write_pad.sv
// image_write_pad
//   Writes one frame of pixels into banked memory, surrounding the image with
//   a border of p zero-valued pixels on every side. Config registers are
//   written over a simple strobe bus and copied into shadow registers when a
//   frame starts, so reprogramming during a frame only affects the next one.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   cfg_data/addr/valid      config register write bus
//   next / next_rdy          frame start request / ready to start (IDLE)
//   str_img_bus/val/rdy      input pixel stream, valid/ready handshake
//   wr_val/bank/addr/data    registered memory write port
//   frame_done               pulses with the last write of a frame
module image_write_pad #(
  parameter  int CFG_DWIDTH = 32,
  parameter  int CFG_AWIDTH = 5,
  parameter  int DEPTH_NB   = 16,
  parameter  int IMG_WIDTH  = 16,
  parameter  int MEM_AWIDTH = 16,
  parameter  int BANK_NB    = 4,
  localparam int BANK_AW    = (BANK_NB > 1) ? $clog2(BANK_NB) : 1,
  localparam int PIX_W      = IMG_WIDTH * DEPTH_NB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cfg_data,
  input  logic [CFG_AWIDTH-1:0] cfg_addr,
  input  logic                  cfg_valid,
  input  logic                  next,
  output logic                  next_rdy,
  input  logic [PIX_W-1:0]      str_img_bus,
  input  logic                  str_img_val,
  output logic                  str_img_rdy,
  output logic                  wr_val,
  output logic [BANK_AW-1:0]    wr_bank,
  output logic [MEM_AWIDTH-1:0] wr_addr,
  output logic [PIX_W-1:0]      wr_data,
  output logic                  frame_done
);

  // Position counters must hold 16-bit dimension plus twice the 4-bit pad.
  localparam int CW = 18;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  // Programmable registers
  logic [15:0]            img_wm1_q, img_wm1_d;
  logic [15:0]            img_hm1_q, img_hm1_d;
  logic [MEM_AWIDTH-1:0]  base_q, base_d;
  logic [15:0]            pstep_q, pstep_d;
  logic [15:0]            rstep_q, rstep_d;
  logic [3:0]             pad_q, pad_d;
  logic [BANK_AW-1:0]     bank_q, bank_d;
  logic                   auto_q, auto_d;

  // Frame shadows
  logic [15:0]            sh_wm1_q, sh_wm1_d;
  logic [15:0]            sh_hm1_q, sh_hm1_d;
  logic [15:0]            sh_pstep_q, sh_pstep_d;
  logic [15:0]            sh_rstep_q, sh_rstep_d;
  logic [3:0]             sh_pad_q, sh_pad_d;
  logic [BANK_AW-1:0]     sh_bank_q, sh_bank_d;

  // Raster position and incrementally tracked addresses
  logic [CW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic [MEM_AWIDTH-1:0]  addr_q, addr_d;
  logic [MEM_AWIDTH-1:0]  row_addr_q, row_addr_d;

  // Output registers
  logic                   wr_val_q, wr_val_d;
  logic [BANK_AW-1:0]     wr_bank_q, wr_bank_d;
  logic [MEM_AWIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]       wr_data_q, wr_data_d;
  logic                   frame_done_q, frame_done_d;

  logic [CW-1:0] p_ext, last_col, last_row;
  logic          is_pad, issue, at_eol, at_end;

  always_comb begin
    p_ext    = CW'(sh_pad_q);
    last_col = CW'(sh_wm1_q) + (p_ext << 1);
    last_row = CW'(sh_hm1_q) + (p_ext << 1);
    is_pad   = (row_q < p_ext) || (row_q > CW'(sh_hm1_q) + p_ext) ||
               (col_q < p_ext) || (col_q > CW'(sh_wm1_q) + p_ext);
    // Padding positions issue unconditionally; image positions wait for data.
    issue    = (state_q == RUN) && (is_pad || str_img_val);
    at_eol   = (col_q == last_col);
    at_end   = at_eol && (row_q == last_row);
  end

  assign next_rdy    = (state_q == IDLE);
  assign str_img_rdy = (state_q == RUN) && !is_pad;

  always_comb begin
    state_d      = state_q;
    img_wm1_d    = img_wm1_q;
    img_hm1_d    = img_hm1_q;
    base_d       = base_q;
    pstep_d      = pstep_q;
    rstep_d      = rstep_q;
    pad_d        = pad_q;
    bank_d       = bank_q;
    auto_d       = auto_q;
    sh_wm1_d     = sh_wm1_q;
    sh_hm1_d     = sh_hm1_q;
    sh_pstep_d   = sh_pstep_q;
    sh_rstep_d   = sh_rstep_q;
    sh_pad_d     = sh_pad_q;
    sh_bank_d    = sh_bank_q;
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    row_addr_d   = row_addr_q;
    wr_val_d     = issue;
    frame_done_d = issue && at_end;
    wr_bank_d    = wr_bank_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (issue) begin
      wr_addr_d = addr_q;
      wr_data_d = is_pad ? '0 : str_img_bus;
      wr_bank_d = sh_bank_q;
    end

    // Auto bank advance at frame end; an explicit BANK write below wins.
    if (issue && at_end && auto_q) begin
      bank_d = (BANK_NB > 1) ? bank_q + BANK_AW'(1) : '0;
    end

    if (cfg_valid) begin
      case (cfg_addr)
        CFG_AWIDTH'(8):  img_wm1_d = cfg_data[15:0];
        CFG_AWIDTH'(9):  begin
          base_d    = MEM_AWIDTH'(cfg_data[31:16]);
          img_hm1_d = cfg_data[15:0];
        end
        CFG_AWIDTH'(10): begin
          pstep_d = cfg_data[31:16];
          rstep_d = cfg_data[15:0];
        end
        CFG_AWIDTH'(11): pad_d = cfg_data[3:0];
        CFG_AWIDTH'(12): begin
          bank_d = cfg_data[BANK_AW-1:0];
          auto_d = cfg_data[16];
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        // Shadows take the _q values, so a same-cycle cfg write is not seen.
        if (next) begin
          state_d    = RUN;
          sh_wm1_d   = img_wm1_q;
          sh_hm1_d   = img_hm1_q;
          sh_pstep_d = pstep_q;
          sh_rstep_d = rstep_q;
          sh_pad_d   = pad_q;
          sh_bank_d  = bank_q;
          row_d      = '0;
          col_d      = '0;
          addr_d     = base_q;
          row_addr_d = base_q;
        end
      end
      RUN: begin
        if (issue) begin
          if (at_end) begin
            state_d = IDLE;
          end else if (at_eol) begin
            col_d      = '0;
            row_d      = row_q + CW'(1);
            row_addr_d = row_addr_q + MEM_AWIDTH'(sh_rstep_q);
            addr_d     = row_addr_q + MEM_AWIDTH'(sh_rstep_q);
          end else begin
            col_d  = col_q + CW'(1);
            addr_d = addr_q + MEM_AWIDTH'(sh_pstep_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      img_wm1_q    <= '0;
      img_hm1_q    <= '0;
      base_q       <= '0;
      pstep_q      <= '0;
      rstep_q      <= '0;
      pad_q        <= '0;
      bank_q       <= '0;
      auto_q       <= 1'b0;
      sh_wm1_q     <= '0;
      sh_hm1_q     <= '0;
      sh_pstep_q   <= '0;
      sh_rstep_q   <= '0;
      sh_pad_q     <= '0;
      sh_bank_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      row_addr_q   <= '0;
      wr_val_q     <= 1'b0;
      wr_bank_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      img_wm1_q    <= img_wm1_d;
      img_hm1_q    <= img_hm1_d;
      base_q       <= base_d;
      pstep_q      <= pstep_d;
      rstep_q      <= rstep_d;
      pad_q        <= pad_d;
      bank_q       <= bank_d;
      auto_q       <= auto_d;
      sh_wm1_q     <= sh_wm1_d;
      sh_hm1_q     <= sh_hm1_d;
      sh_pstep_q   <= sh_pstep_d;
      sh_rstep_q   <= sh_rstep_d;
      sh_pad_q     <= sh_pad_d;
      sh_bank_q    <= sh_bank_d;
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      row_addr_q   <= row_addr_d;
      wr_val_q     <= wr_val_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_val     = wr_val_q;
  assign wr_bank    = wr_bank_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_image_write_pad.sv
// tb_image_write_pad
//   Bench for image_write_pad. A reference model expands each frame's config
//   into the full list of expected writes (raster walk, padding, address
//   arithmetic, bank) and a monitor checks every DUT write against it.
module tb_image_write_pad;

  logic         clk, rst;
  logic [31:0]  cfg_data;
  logic [4:0]   cfg_addr;
  logic         cfg_valid, next, next_rdy;
  logic [255:0] str_img_bus;
  logic         str_img_val, str_img_rdy;
  logic         wr_val;
  logic [1:0]   wr_bank;
  logic [15:0]  wr_addr;
  logic [255:0] wr_data;
  logic         frame_done;

  image_write_pad dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .next(next), .next_rdy(next_rdy),
    .str_img_bus(str_img_bus), .str_img_val(str_img_val), .str_img_rdy(str_img_rdy),
    .wr_val(wr_val), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [15:0]  addr;
    logic [255:0] data;
    logic [1:0]   bank;
    logic         last;
  } exp_t;

  typedef struct {
    int wm1, hm1, base, pstep, rstep, pad, mode;
    int exp_writes, exp_first, exp_last;
  } vec_t;

  exp_t         exp_q[$];
  logic [255:0] pixmem [0:2047];
  int n_chk, n_fail;
  int src_idx, m_pix_idx, mode;
  int m_wm1, m_hm1, m_base, m_pstep, m_rstep, m_pad, m_bank, m_auto;
  int mon_writes, mon_dones, mon_first, mon_last, mon_bank;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failx(input string name, input int val);
    n_chk++;
    n_fail++;
    $display("FAIL %s: observed %0h", name, val);
  endtask

  task automatic model_reset();
    m_wm1 = 0; m_hm1 = 0; m_base = 0; m_pstep = 0; m_rstep = 0;
    m_pad = 0; m_bank = 0; m_auto = 0;
  endtask

  task automatic model_cfg(input logic [4:0] a, input logic [31:0] d);
    case (a)
      5'd8:  m_wm1 = int'(d[15:0]);
      5'd9:  begin m_base = int'(d[31:16]); m_hm1 = int'(d[15:0]); end
      5'd10: begin m_pstep = int'(d[31:16]); m_rstep = int'(d[15:0]); end
      5'd11: m_pad = int'(d[3:0]);
      5'd12: begin m_bank = int'(d[1:0]); m_auto = int'(d[16]); end
      default: ;
    endcase
  endtask

  // Expand the current model config into the ordered list of writes.
  task automatic build_expected();
    int w, h, p;
    bit pd;
    exp_t e;
    w = m_wm1 + 1; h = m_hm1 + 1; p = m_pad;
    for (int r = 0; r < h + 2*p; r++) begin
      for (int c = 0; c < w + 2*p; c++) begin
        pd = (r < p) || (r >= h + p) || (c < p) || (c >= w + p);
        e.addr = 16'((m_base + r*m_rstep + c*m_pstep) & 32'hFFFF);
        if (pd) e.data = '0;
        else begin
          e.data = pixmem[m_pix_idx % 2048];
          m_pix_idx++;
        end
        e.bank = 2'(m_bank);
        e.last = (r == h + 2*p - 1) && (c == w + 2*p - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (wr_val) begin
      mon_writes++;
      if (mon_writes == 1) begin
        mon_first = int'(wr_addr);
        mon_bank  = int'(wr_bank);
      end
      mon_last = int'(wr_addr);
      if (exp_q.size() == 0) failx("spurious_write", int'(wr_addr));
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("wr_bank", wr_bank, e.bank);
        chk("frame_done", frame_done, e.last);
      end
    end else if (frame_done) failx("done_without_val", 1);
    if (frame_done) mon_dones++;
  endtask

  // Sample at the falling edge, then drive the pixel source after the rise.
  task automatic tick();
    @(negedge clk);
    monitor();
    if (str_img_val && str_img_rdy) src_idx++;
    @(posedge clk);
    #1;
    case (mode)
      0:       str_img_val = 1'b1;
      1:       str_img_val = !str_img_val;
      default: str_img_val = 1'($urandom_range(0, 1));
    endcase
    str_img_bus = pixmem[src_idx % 2048];
  endtask

  task automatic cfg_w(input logic [4:0] a, input logic [31:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    model_cfg(a, d);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic start_frame(input bit cw, input logic [4:0] a, input logic [31:0] d);
    int b;
    b = 0;
    while (!next_rdy && b < 200) begin tick(); b++; end
    if (!next_rdy) failx("next_rdy_timeout", b);
    mon_writes = 0; mon_dones = 0; mon_first = -1; mon_last = -1; mon_bank = -1;
    build_expected();
    next = 1'b1;
    if (cw) begin
      cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
      model_cfg(a, d);
    end
    tick();
    next = 1'b0; cfg_valid = 1'b0;
    chk("busy_after_next", next_rdy, 1'b0);
  endtask

  task automatic finish_frame(input bit settle);
    int b;
    b = 0;
    while (exp_q.size() > 0 && b < 6000) begin tick(); b++; end
    if (exp_q.size() > 0) begin
      failx("frame_timeout", exp_q.size());
      exp_q.delete();
    end
    if (m_auto != 0) m_bank = (m_bank + 1) % 4;
    if (settle) begin tick(); tick(); end
  endtask

  task automatic cfg_vec(input vec_t v);
    cfg_w(5'd8,  {16'h0, 16'(v.wm1)});
    cfg_w(5'd9,  {16'(v.base), 16'(v.hm1)});
    cfg_w(5'd10, {16'(v.pstep), 16'(v.rstep)});
    cfg_w(5'd11, 32'(v.pad));
    cfg_w(5'd13, 32'hFFFF_FFFF);
    cfg_w(5'd7,  32'hFFFF_FFFF);
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    n_chk = 0; n_fail = 0; src_idx = 0; m_pix_idx = 0; mode = 0;
    for (int i = 0; i < 2048; i++)
      for (int k = 0; k < 8; k++) pixmem[i][k*32 +: 32] = $urandom;
    rst = 1'b1; cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0; next = 1'b0;
    str_img_val = 1'b0; str_img_bus = pixmem[0];
    model_reset();

    //                wm1 hm1 base    pstep rstep pad mode  writes first   last
    vecs[0] = '{ 9,  4,  0,      4,    40,   0,  0,    50,    0,      196};
    vecs[1] = '{ 1,  1,  0,      1,    4,    1,  0,    16,    0,      15};
    vecs[2] = '{ 9,  4,  0,      4,    40,   0,  1,    50,    0,      196};
    vecs[3] = '{ 3,  0,  'hFFFE, 1,    0,    0,  0,    4,     'hFFFE, 1};
    vecs[4] = '{ 2,  1,  'h100,  2,    'h20, 2,  2,    42,    'h100,  'h1AC};

    #12;
    chk("rst_next_rdy", next_rdy, 1'b1);
    chk("rst_img_rdy", str_img_rdy, 1'b0);
    chk("rst_wr_val", wr_val, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_wr_addr", wr_addr, 16'h0);
    chk("rst_wr_bank", wr_bank, 2'h0);
    chk("rst_wr_data", wr_data, 256'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cleared config describes a single 1x1 frame at address 0, bank 0.
    start_frame(1'b0, 5'd0, 32'h0);
    finish_frame(1'b1);
    chk("dflt_writes", 256'(mon_writes), 256'(1));
    chk("dflt_first", 256'(mon_first), 256'(0));

    for (int i = 0; i < 5; i++) begin
      mode = vecs[i].mode;
      cfg_vec(vecs[i]);
      start_frame(1'b0, 5'd0, 32'h0);
      finish_frame(1'b1);
      chk("vec_writes", 256'(mon_writes), 256'(vecs[i].exp_writes));
      chk("vec_dones", 256'(mon_dones), 256'(1));
      chk("vec_first", 256'(mon_first), 256'(vecs[i].exp_first));
      chk("vec_last", 256'(mon_last), 256'(vecs[i].exp_last));
    end

    mode = 2;
    for (int i = 0; i < 6; i++) begin
      rv.wm1 = $urandom_range(0, 5); rv.hm1 = $urandom_range(0, 3);
      rv.pad = $urandom_range(0, 3); rv.base = $urandom_range(0, 65535);
      rv.pstep = $urandom_range(0, 65535); rv.rstep = $urandom_range(0, 65535);
      cfg_vec(rv);
      start_frame(1'b0, 5'd0, 32'h0);
      finish_frame(1'b1);
      chk("rnd_writes", 256'(mon_writes),
          256'((rv.wm1 + 1 + 2*rv.pad) * (rv.hm1 + 1 + 2*rv.pad)));
      chk("rnd_dones", 256'(mon_dones), 256'(1));
    end

    // Bank auto-increment over back-to-back frames, IMG_W changed mid-frame.
    mode = 0;
    rv = '{3, 1, 0, 1, 4, 0, 0, 0, 0, 0};
    cfg_vec(rv);
    cfg_w(5'd12, 32'h0001_0003);
    start_frame(1'b0, 5'd0, 32'h0);
    tick(); tick();
    cfg_w(5'd8, 32'h1);
    finish_frame(1'b0);
    chk("bank_f1", 256'(mon_bank), 256'(3));
    chk("bank_f1_writes", 256'(mon_writes), 256'(8));
    start_frame(1'b0, 5'd0, 32'h0);
    finish_frame(1'b1);
    chk("bank_f2", 256'(mon_bank), 256'(0));
    chk("bank_f2_writes", 256'(mon_writes), 256'(4));
    cfg_w(5'd12, 32'h0);

    // cfg write coinciding with next: this frame keeps pad 0, next gets pad 2.
    rv = '{1, 0, 0, 1, 8, 0, 0, 0, 0, 0};
    cfg_vec(rv);
    start_frame(1'b1, 5'd11, 32'h2);
    finish_frame(1'b1);
    chk("samecyc_f1_writes", 256'(mon_writes), 256'(2));
    start_frame(1'b0, 5'd0, 32'h0);
    finish_frame(1'b1);
    chk("samecyc_f2_writes", 256'(mon_writes), 256'(30));

    // Reset in the middle of a 50-write frame.
    mode = 0;
    cfg_vec(vecs[0]);
    start_frame(1'b0, 5'd0, 32'h0);
    for (int b = 0; b < 200 && mon_writes < 7; b++) tick();
    chk("pre_rst_writes", 256'(mon_writes), 256'(7));
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_val", wr_val, 1'b0);
    chk("mid_rst_wr_addr", wr_addr, 16'h0);
    chk("mid_rst_wr_data", wr_data, 256'h0);
    chk("mid_rst_done", frame_done, 1'b0);
    chk("mid_rst_next_rdy", next_rdy, 1'b1);
    chk("mid_rst_img_rdy", str_img_rdy, 1'b0);
    exp_q.delete();
    model_reset();
    m_pix_idx = src_idx;
    mon_dones = 0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_no_done", 256'(mon_dones), 256'(0));
    cfg_vec(vecs[0]);
    start_frame(1'b0, 5'd0, 32'h0);
    finish_frame(1'b1);
    chk("restart_first", 256'(mon_first), 256'(0));
    chk("restart_writes", 256'(mon_writes), 256'(50));
    chk("restart_dones", 256'(mon_dones), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/image_write_pad.md
IMAGE_WRITE_PAD -- requirements
Module: image_write_pad

Interface
REQ-001 CFG_DWIDTH, 32, config data width.
REQ-002 CFG_AWIDTH, 5, config address width.
REQ-003 DEPTH_NB, 16, channels per pixel.
REQ-004 IMG_WIDTH, 16, bits per channel.
REQ-005 MEM_AWIDTH, 16, memory word address width.
REQ-006 BANK_NB, 4, memory banks; power of 2; BANK_AW = max(1, clog2(BANK_NB)).
REQ-007 Block SHALL use one clock; reset is asynchronous and active-high.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 cfg_data  in  CFG_DWIDTH  config write data.
REQ-011 cfg_addr  in  CFG_AWIDTH  config register address.
REQ-012 cfg_valid  in  1  config write strobe.
REQ-013 next  in  1  frame start request.
REQ-014 next_rdy  out  1  high when IDLE; a frame can start.
REQ-015 str_img_bus  in  IMG_WIDTH*DEPTH_NB  input pixel.
REQ-016 str_img_val / str_img_rdy  in / out  1 / 1  pixel stream handshake.
REQ-017 wr_val  out  1  memory write strobe.
REQ-018 wr_bank  out  BANK_AW  target bank.
REQ-019 wr_addr  out  MEM_AWIDTH  target word address.
REQ-020 wr_data  out  IMG_WIDTH*DEPTH_NB  write data.
REQ-021 frame_done  out  1  one-cycle pulse with the frame's last write.

Function
REQ-022 Config registers SHALL be written when cfg_valid=1 at the addresses below; other addresses are ignored: 8 IMG_W[15:0]=W-1; 9 START[31:16]=base address, [15:0]=H-1; 10 STEP[31:16]=pixel step, [15:0]=row step (literal, not minus one); 11 PAD[3:0]=p (0..15); 12 BANK[BANK_AW-1:0]=bank, [16]=auto-increment.
REQ-023 On next=1 while next_rdy=1, all config SHALL be copied into active shadow registers; later cfg writes SHALL affect only the next frame; next while busy SHALL be ignored.
REQ-024 States: IDLE -> RUN on accepted next; RUN -> IDLE after last position issued.
REQ-025 RUN SHALL visit positions (r,c) in raster order, r in 0..H+2p-1, c in 0..W+2p-1 (W=IMG_W+1, H=START[15:0]+1).
REQ-026 Position is padding if r<p, r>=H+p, c<p or c>=W+p; padding SHALL issue one zero-data write per cycle with str_img_rdy=0 and consume no input.
REQ-027 Image positions: str_img_rdy=1; position advances only on str_img_val & str_img_rdy; no val means stall, no write.
REQ-028 Address = base + r*row_step + c*pixel_step, computed incrementally and truncated mod 2^MEM_AWIDTH (wrap permitted).
REQ-029 wr_val/wr_addr/wr_data/wr_bank SHALL be registered, exactly 1 cycle after the position is issued or accepted; wr_data equals the accepted pixel unmodified.
REQ-030 frame_done SHALL assert in the same cycle as the last wr_val of a frame.
REQ-031 wr_bank SHALL be the shadow bank; if auto-increment set, the BANK register increments mod BANK_NB at frame end, so a further next without reconfiguration targets the following bank.
REQ-032 str_img_rdy SHALL be 0 in IDLE; next_rdy returns 1 the cycle after the last position is issued; back-to-back frames are allowed (wr_val of frame N may coincide with first issue of N+1).
REQ-033 cfg write and accepted next in the same cycle: the shadow SHALL capture the pre-write value.

Reset
REQ-034 rst SHALL asynchronously force IDLE, next_rdy=1, str_img_rdy=0, wr_val=0, frame_done=0, wr_addr=0, wr_bank=0, wr_data=0, all config registers 0.
REQ-035 rst mid-frame SHALL abort the frame with no further writes and no frame_done.

Verification
REQ-036 W=10,H=5,base=0,pixel=4,row=40,p=0, val held 1 -> 50 writes, addresses 0,4..36,40..196, data equals input sequence, one frame_done.
REQ-037 W=2,H=2,p=1,pixel=1,row=4 -> 16 writes, addr 0..15; 12 zero, data at 5,6,9,10 equals pixels 1..4; rdy=0 on pads.
REQ-038 Toggle str_img_val every other cycle -> writes only on accepted cycles, address order unchanged.
REQ-039 BANK=3,auto=1,BANK_NB=4, two frames -> wr_bank 3 then 0; IMG_W rewritten mid-frame affects only frame 2.
REQ-040 base=0xFFFE,pixel=1,W=4,H=1 -> addresses FFFE,FFFF,0000,0001.
REQ-041 rst asserted at write 7 of 50 -> outputs at reset values immediately; next frame restarts at base.
